// File: rtl/region_decoder_pkg.sv
//------------------------------------------------------------------------------
// Module   : region_decoder_pkg
// Purpose  : FSM state encoding, region names and the reset decode map.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package region_decoder_pkg;

  localparam int MAX_REGIONS = 16;

  localparam int REG_ROM  = 0;
  localparam int REG_RAM  = 1;
  localparam int REG_IO   = 2;
  localparam int REG_CAN  = 3;
  localparam int REG_DRAM = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_BERR   = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_BASE [MAX_REGIONS] = '{
    REG_ROM:  32'h0000_0000,
    REG_RAM:  32'hF000_0000,
    REG_IO:   32'h0040_0000,
    REG_CAN:  32'h0050_0000,
    REG_DRAM: 32'h0800_0000,
    default:  32'h0000_0000
  };

  localparam logic [31:0] DEFAULT_MASK [MAX_REGIONS] = '{
    REG_ROM:  32'hFFFF_8000,
    REG_RAM:  32'hFFFC_0000,
    REG_IO:   32'hFFFF_0000,
    REG_CAN:  32'hFFFF_0000,
    REG_DRAM: 32'hFC00_0000,
    default:  32'h0000_0000
  };

  localparam logic [MAX_REGIONS-1:0] DEFAULT_ENABLE = 16'h001F;

endpackage

`default_nettype wire

// File: rtl/region_match.sv
//------------------------------------------------------------------------------
// Module   : region_match
// Purpose  : Combinational base/mask compare with lowest-index priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module region_match
  import region_decoder_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 32
) (
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0] i_base,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0] i_mask,
  input  logic [NUM_REGIONS-1:0]             i_enable,
  output logic [NUM_REGIONS-1:0]             o_sel,
  output logic                               o_hit
);

  logic [NUM_REGIONS-1:0] w_raw;

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_cmp
    assign w_raw[gi] = i_enable[gi] &&
                       ((i_addr & i_mask[gi]) == (i_base[gi] & i_mask[gi]));
  end

  // Isolating the lowest set bit gives lowest-index-wins priority.
  assign o_sel = w_raw & (~w_raw + NUM_REGIONS'(1));
  assign o_hit = |w_raw;

endmodule

`default_nettype wire

// File: rtl/region_decoder.sv
//------------------------------------------------------------------------------
// Module   : region_decoder
// Purpose  : Registered, programmable 68000 chip-select decoder.
//            REGION_DECODER_TIMEOUT_EN adds DTACK timeout and unmapped bus error.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module region_decoder
  import region_decoder_pkg::*;
#(
  parameter int NUM_REGIONS    = 8,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   Clock,
  input  logic                   Reset_L,
  input  logic [ADDR_W-1:0]      Address,
  input  logic                   AS_L,
  input  logic                   DTACK_L,
  input  logic                   CfgWrite_H,
  input  logic [IDX_W-1:0]       CfgIndex,
  input  logic [ADDR_W-1:0]      CfgBase,
  input  logic [ADDR_W-1:0]      CfgMask,
  input  logic                   CfgEnable_H,
  output logic [NUM_REGIONS-1:0] Select_H,
  output logic                   Unmapped_H,
  output logic                   BerrOut_L
);

  logic [NUM_REGIONS-1:0][ADDR_W-1:0] base_q, base_d, mask_q, mask_d;
  logic [NUM_REGIONS-1:0]             enable_q, enable_d;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NUM_REGIONS-1:0] match_sel_q, match_sel_d;
  logic                   match_unm_q, match_unm_d;
  logic [NUM_REGIONS-1:0] sel_q, sel_d;
  logic                   unm_q, unm_d;
  logic                   berr_n_q, berr_n_d;

  logic [NUM_REGIONS-1:0] w_sel;
  logic                   w_hit;
  logic                   w_timeout;

  region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W)
  ) u_match (
    .i_addr   (addr_q),
    .i_base   (base_q),
    .i_mask   (mask_q),
    .i_enable (enable_q),
    .o_sel    (w_sel),
    .o_hit    (w_hit)
  );

  always_comb begin
    base_d   = base_q;
    mask_d   = mask_q;
    enable_d = enable_q;
    if (CfgWrite_H && (int'(CfgIndex) < NUM_REGIONS)) begin
      base_d[CfgIndex]   = CfgBase;
      mask_d[CfgIndex]   = CfgMask;
      enable_d[CfgIndex] = CfgEnable_H;
    end
  end

`ifdef REGION_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dtack_seen_q, dtack_seen_d;

  // Once the slave has acknowledged, the count freezes for the rest of the cycle.
  always_comb begin
    cnt_d        = cnt_q;
    dtack_seen_d = dtack_seen_q;
    if (state_q == ST_DECODE) begin
      cnt_d        = '0;
      dtack_seen_d = 1'b0;
    end else if (state_q == ST_ACTIVE && !dtack_seen_q) begin
      if (!DTACK_L) dtack_seen_d = 1'b1;
      else          cnt_d        = cnt_q + CNT_W'(1);
    end
  end

  // Fires on the edge that would bring the count to TIMEOUT_CYCLES; a DTACK on that edge wins.
  assign w_timeout = (state_q == ST_ACTIVE) && !AS_L && !dtack_seen_q && DTACK_L &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt_q        <= '0;
      dtack_seen_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dtack_seen_q <= dtack_seen_d;
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  logic w_unused_dtack;
  assign w_unused_dtack = DTACK_L;
  assign w_timeout      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    match_sel_d = match_sel_q;
    match_unm_d = match_unm_q;
    case (state_q)
      ST_IDLE: begin
        if (!AS_L) begin
          addr_d  = Address;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (AS_L) begin
          state_d = ST_IDLE;
        end else begin
          match_sel_d = w_sel;
          match_unm_d = !w_hit;
`ifdef REGION_DECODER_TIMEOUT_EN
          state_d     = w_hit ? ST_ACTIVE : ST_BERR;
`else
          state_d     = ST_ACTIVE;
`endif
        end
      end
      ST_ACTIVE: begin
        if (AS_L)           state_d = ST_IDLE;
        else if (w_timeout) state_d = ST_BERR;
      end
`ifdef REGION_DECODER_TIMEOUT_EN
      ST_BERR: begin
        if (AS_L) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the current state one edge later, giving the k+2 / m+1 latencies.
  always_comb begin
    sel_d    = '0;
    unm_d    = 1'b0;
    berr_n_d = 1'b1;
    case (state_q)
      ST_ACTIVE: begin
        unm_d = match_unm_q;
        if (w_timeout) berr_n_d = 1'b0;
        else           sel_d    = match_sel_q;
      end
`ifdef REGION_DECODER_TIMEOUT_EN
      ST_BERR: begin
        unm_d    = match_unm_q;
        berr_n_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]   <= ADDR_W'(DEFAULT_BASE[i]);
        mask_q[i]   <= ADDR_W'(DEFAULT_MASK[i]);
        enable_q[i] <= DEFAULT_ENABLE[i];
      end
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      match_sel_q <= '0;
      match_unm_q <= 1'b0;
      sel_q       <= '0;
      unm_q       <= 1'b0;
      berr_n_q    <= 1'b1;
    end else begin
      base_q      <= base_d;
      mask_q      <= mask_d;
      enable_q    <= enable_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      match_sel_q <= match_sel_d;
      match_unm_q <= match_unm_d;
      sel_q       <= sel_d;
      unm_q       <= unm_d;
      berr_n_q    <= berr_n_d;
    end
  end

  assign Select_H   = sel_q;
  assign Unmapped_H = unm_q;
  assign BerrOut_L  = berr_n_q;

endmodule

`default_nettype wire

// File: tb/tb_region_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_region_decoder
// Purpose  : Directed, table-driven bench for region_decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_region_decoder;

`ifdef REGION_DECODER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        Clock;
  logic        Reset_L;
  logic [31:0] Address;
  logic        AS_L;
  logic        DTACK_L;
  logic        CfgWrite_H;
  logic [2:0]  CfgIndex;
  logic [31:0] CfgBase;
  logic [31:0] CfgMask;
  logic        CfgEnable_H;
  logic [7:0]  Select_H;
  logic        Unmapped_H;
  logic        BerrOut_L;

  int n_tests = 0;
  int n_fail  = 0;

  region_decoder #(
    .NUM_REGIONS    (8),
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .Clock       (Clock),
    .Reset_L     (Reset_L),
    .Address     (Address),
    .AS_L        (AS_L),
    .DTACK_L     (DTACK_L),
    .CfgWrite_H  (CfgWrite_H),
    .CfgIndex    (CfgIndex),
    .CfgBase     (CfgBase),
    .CfgMask     (CfgMask),
    .CfgEnable_H (CfgEnable_H),
    .Select_H    (Select_H),
    .Unmapped_H  (Unmapped_H),
    .BerrOut_L   (BerrOut_L)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] b,
                           input logic [31:0] m, input logic en);
    @(negedge Clock);
    CfgWrite_H = 1'b1; CfgIndex = idx; CfgBase = b; CfgMask = m; CfgEnable_H = en;
    @(negedge Clock);
    CfgWrite_H = 1'b0;
  endtask

  // Full bus cycle; race=1 disables entry 0 on the same edge the address is latched.
  task automatic access(input string pfx, input logic [31:0] addr,
                        input logic [7:0] es, input logic eu, input bit race);
    @(negedge Clock);
    Address = addr; AS_L = 1'b0; DTACK_L = 1'b0;
    if (race) begin
      CfgWrite_H = 1'b1; CfgIndex = 3'd0; CfgBase = 32'h0;
      CfgMask = 32'hFFFF_8000; CfgEnable_H = 1'b0;
    end
    @(posedge Clock); #1;
    CfgWrite_H = 1'b0;
    chk({pfx, "_sel_k"}, 32'(Select_H), 32'h0);
    @(posedge Clock); #1;
    chk({pfx, "_sel_k1"}, 32'(Select_H), 32'h0);
    @(posedge Clock); #1;
    chk({pfx, "_sel"},  32'(Select_H),   32'(es));
    chk({pfx, "_unm"},  32'(Unmapped_H), 32'(eu));
    chk({pfx, "_berr"}, 32'(BerrOut_L),  32'(!(eu && TO_EN)));
    @(negedge Clock);
    AS_L = 1'b1; DTACK_L = 1'b1;
    @(posedge Clock); #1;
    chk({pfx, "_sel_m"}, 32'(Select_H), 32'(es));
    @(posedge Clock); #1;
    chk({pfx, "_sel_rel"},  32'(Select_H),   32'h0);
    chk({pfx, "_unm_rel"},  32'(Unmapped_H), 32'h0);
    chk({pfx, "_berr_rel"}, 32'(BerrOut_L),  32'h1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  sel;
    logic        unm;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'h0040_0010, 8'h04, 1'b0};
    vecs[1] = '{32'h0000_0100, 8'h01, 1'b0};
    vecs[2] = '{32'h0000_7FFF, 8'h01, 1'b0};
    vecs[3] = '{32'h0000_8000, 8'h00, 1'b1};
    vecs[4] = '{32'hF003_FFFF, 8'h02, 1'b0};
    vecs[5] = '{32'hF004_0000, 8'h00, 1'b1};
    vecs[6] = '{32'h0050_ABCD, 8'h08, 1'b0};
    vecs[7] = '{32'h0800_0000, 8'h10, 1'b0};
    vecs[8] = '{32'h0BFF_FFFC, 8'h10, 1'b0};
    vecs[9] = '{32'h3000_0000, 8'h00, 1'b1};

    Reset_L = 1'b0; Address = '0; AS_L = 1'b1; DTACK_L = 1'b1;
    CfgWrite_H = 1'b0; CfgIndex = '0; CfgBase = '0; CfgMask = '0; CfgEnable_H = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_sel",  32'(Select_H),   32'h0);
    chk("rst_unm",  32'(Unmapped_H), 32'h0);
    chk("rst_berr", 32'(BerrOut_L),  32'h1);
    @(negedge Clock);
    Reset_L = 1'b1;

    for (int i = 0; i < 10; i++)
      access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].sel, vecs[i].unm, 1'b0);

    // One-edge address strobe aborts in DECODE.
    @(negedge Clock);
    Address = 32'h0040_0010; AS_L = 1'b0;
    @(negedge Clock);
    AS_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      chk($sformatf("pulse_sel%0d", i), 32'(Select_H), 32'h0);
      chk($sformatf("pulse_unm%0d", i), 32'(Unmapped_H), 32'h0);
    end

    access("race",  32'h0000_0100, 8'h00, 1'b1, 1'b1);
    access("race2", 32'h0000_0100, 8'h00, 1'b1, 1'b0);

    cfg_write(3'd1, 32'h0040_0000, 32'hFFFF_0000, 1'b1);
    access("prio", 32'h0040_1234, 8'h02, 1'b0, 1'b0);

`ifdef REGION_DECODER_TIMEOUT_EN
    cfg_write(3'd1, 32'hF000_0000, 32'hFFFC_0000, 1'b1);

    // DTACK never arrives: bus error after the 4th ACTIVE edge.
    @(negedge Clock);
    Address = 32'hF000_0000; AS_L = 1'b0; DTACK_L = 1'b1;
    repeat (2) @(posedge Clock);
    repeat (3) @(posedge Clock);
    #1;
    chk("to_pre_sel",  32'(Select_H),  32'h02);
    chk("to_pre_berr", 32'(BerrOut_L), 32'h1);
    @(posedge Clock); #1;
    chk("to_sel",  32'(Select_H),  32'h0);
    chk("to_berr", 32'(BerrOut_L), 32'h0);
    repeat (3) @(posedge Clock);
    #1;
    chk("to_hold_berr", 32'(BerrOut_L), 32'h0);
    @(negedge Clock);
    AS_L = 1'b1;
    @(posedge Clock); #1;
    chk("to_m_berr", 32'(BerrOut_L), 32'h0);
    @(posedge Clock); #1;
    chk("to_rel_berr", 32'(BerrOut_L), 32'h1);
    chk("to_rel_sel",  32'(Select_H),  32'h0);

    // DTACK on exactly the 4th ACTIVE edge wins and freezes the count.
    @(negedge Clock);
    Address = 32'hF000_0000; AS_L = 1'b0; DTACK_L = 1'b1;
    repeat (2) @(posedge Clock);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    DTACK_L = 1'b0;
    @(posedge Clock); #1;
    chk("bnd_sel",  32'(Select_H),  32'h02);
    chk("bnd_berr", 32'(BerrOut_L), 32'h1);
    @(negedge Clock);
    DTACK_L = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    chk("bnd_hold_sel",  32'(Select_H),  32'h02);
    chk("bnd_hold_berr", 32'(BerrOut_L), 32'h1);
    @(negedge Clock);
    AS_L = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("bnd_rel_sel", 32'(Select_H), 32'h0);
`endif

    // Asynchronous reset in the middle of an active cycle.
    @(negedge Clock);
    Address = 32'h0050_0000; AS_L = 1'b0; DTACK_L = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("mid_sel_pre", 32'(Select_H), 32'h08);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("mid_sel",  32'(Select_H),   32'h0);
    chk("mid_unm",  32'(Unmapped_H), 32'h0);
    chk("mid_berr", 32'(BerrOut_L),  32'h1);
    @(negedge Clock);
    AS_L = 1'b1; DTACK_L = 1'b1;
    @(negedge Clock);
    Reset_L = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("post_rst_sel", 32'(Select_H), 32'h0);

    // Reset restores the default table, so ROM is mapped again.
    access("rom_again", 32'h0000_0100, 8'h01, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
